// File: rtl/pcie_cfg_fc_pkg.sv
// Shared types and default widths for the PCIe configuration flow-control sampler.
package pcie_cfg_fc_pkg;

  localparam int C_DEF_PH_WIDTH    = 8;
  localparam int C_DEF_PD_WIDTH    = 12;
  localparam int C_DEF_NPH_WIDTH   = 8;
  localparam int C_DEF_NPD_WIDTH   = 12;
  localparam int C_DEF_CPLH_WIDTH  = 8;
  localparam int C_DEF_CPLD_WIDTH  = 12;
  localparam int C_DEF_SEL_WIDTH   = 3;
  localparam int C_DEF_NUM_SEL     = 3;
  localparam int C_DEF_SEL_LATENCY = 2;
  localparam int C_DEF_PERIOD      = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_PRESENT = 2'd3
  } fc_state_e;

  // Default-width view of one snapshot, for shell logic that packs snapshots.
  typedef struct packed {
    logic [C_DEF_SEL_WIDTH-1:0]  sel;
    logic                        last;
    logic [C_DEF_PH_WIDTH-1:0]   ph;
    logic [C_DEF_PD_WIDTH-1:0]   pd;
    logic [C_DEF_NPH_WIDTH-1:0]  nph;
    logic [C_DEF_NPD_WIDTH-1:0]  npd;
    logic [C_DEF_CPLH_WIDTH-1:0] cplh;
    logic [C_DEF_CPLD_WIDTH-1:0] cpld;
  } fc_snap_t;

endpackage

// File: rtl/pcie_cfg_fc_trigger.sv
// Merges the external start request with an optional free-running period timer
// into a single-cycle sweep trigger.
module pcie_cfg_fc_trigger #(
  parameter int C_PERIOD = 0
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic i_start,
  output logic o_trigger
);

  localparam int                  LP_CNT_W     = 24;
  localparam bit                  LP_TIMER_EN  = (C_PERIOD > 0);
  localparam logic [LP_CNT_W-1:0] LP_CNT_LAST  = LP_TIMER_EN ? LP_CNT_W'(C_PERIOD - 1) : '0;

  logic [LP_CNT_W-1:0] r_cnt;
  logic                w_tick;

  assign w_tick = LP_TIMER_EN && (r_cnt == LP_CNT_LAST);

  // The timer keeps counting during a sweep; expiries while busy become overruns upstream.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt <= '0;
    end else if (!LP_TIMER_EN || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_trigger = i_start | w_tick;

endmodule

// File: rtl/pcie_cfg_fc_sampler.sv
// Walks the PCIe core's FC SEL codes, waits out the core latency for each,
// and hands every captured credit set downstream as a valid/ready snapshot.
module pcie_cfg_fc_sampler
  import pcie_cfg_fc_pkg::*;
#(
  parameter int C_PH_WIDTH    = C_DEF_PH_WIDTH,
  parameter int C_PD_WIDTH    = C_DEF_PD_WIDTH,
  parameter int C_NPH_WIDTH   = C_DEF_NPH_WIDTH,
  parameter int C_NPD_WIDTH   = C_DEF_NPD_WIDTH,
  parameter int C_CPLH_WIDTH  = C_DEF_CPLH_WIDTH,
  parameter int C_CPLD_WIDTH  = C_DEF_CPLD_WIDTH,
  parameter int C_SEL_WIDTH   = C_DEF_SEL_WIDTH,
  parameter int C_NUM_SEL     = C_DEF_NUM_SEL,
  parameter int C_SEL_LATENCY = C_DEF_SEL_LATENCY,
  parameter int C_PERIOD      = C_DEF_PERIOD
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    start,
  output logic [C_SEL_WIDTH-1:0]  fc_sel,
  input  logic [C_PH_WIDTH-1:0]   fc_ph,
  input  logic [C_PD_WIDTH-1:0]   fc_pd,
  input  logic [C_NPH_WIDTH-1:0]  fc_nph,
  input  logic [C_NPD_WIDTH-1:0]  fc_npd,
  input  logic [C_CPLH_WIDTH-1:0] fc_cplh,
  input  logic [C_CPLD_WIDTH-1:0] fc_cpld,
  output logic                    snap_valid,
  input  logic                    snap_ready,
  output logic [C_SEL_WIDTH-1:0]  snap_sel,
  output logic                    snap_last,
  output logic [C_PH_WIDTH-1:0]   snap_ph,
  output logic [C_PD_WIDTH-1:0]   snap_pd,
  output logic [C_NPH_WIDTH-1:0]  snap_nph,
  output logic [C_NPD_WIDTH-1:0]  snap_npd,
  output logic [C_CPLH_WIDTH-1:0] snap_cplh,
  output logic [C_CPLD_WIDTH-1:0] snap_cpld,
  output logic                    busy,
  output logic                    overrun
);

  localparam logic [3:0]             LP_WAIT_LAST = 4'(C_SEL_LATENCY - 1);
  localparam logic [C_SEL_WIDTH-1:0] LP_SEL_LAST  = C_SEL_WIDTH'(C_NUM_SEL - 1);

  logic w_trigger;

  fc_state_e               r_state;
  logic [3:0]              r_wait;
  logic [C_SEL_WIDTH-1:0]  r_fc_sel;
  logic                    r_busy;
  logic                    r_overrun;
  logic                    r_snap_valid;
  logic [C_SEL_WIDTH-1:0]  r_snap_sel;
  logic                    r_snap_last;
  logic [C_PH_WIDTH-1:0]   r_snap_ph;
  logic [C_PD_WIDTH-1:0]   r_snap_pd;
  logic [C_NPH_WIDTH-1:0]  r_snap_nph;
  logic [C_NPD_WIDTH-1:0]  r_snap_npd;
  logic [C_CPLH_WIDTH-1:0] r_snap_cplh;
  logic [C_CPLD_WIDTH-1:0] r_snap_cpld;

  pcie_cfg_fc_trigger #(
    .C_PERIOD (C_PERIOD)
  ) u_trigger (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .i_start   (start),
    .o_trigger (w_trigger)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= ST_IDLE;
      r_wait       <= '0;
      r_fc_sel     <= '0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_snap_valid <= 1'b0;
      r_snap_sel   <= '0;
      r_snap_last  <= 1'b0;
      r_snap_ph    <= '0;
      r_snap_pd    <= '0;
      r_snap_nph   <= '0;
      r_snap_npd   <= '0;
      r_snap_cplh  <= '0;
      r_snap_cpld  <= '0;
    end else begin
      // Any state other than IDLE is busy, including the final handshake cycle.
      if (w_trigger && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            r_state  <= ST_SETTLE;
            r_fc_sel <= '0;
            r_wait   <= '0;
            r_busy   <= 1'b1;
          end
        end
        ST_SETTLE: begin
          r_wait <= r_wait + 4'd1;
          if (r_wait == LP_WAIT_LAST) begin
            r_state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          r_snap_sel   <= r_fc_sel;
          r_snap_last  <= (r_fc_sel == LP_SEL_LAST);
          r_snap_ph    <= fc_ph;
          r_snap_pd    <= fc_pd;
          r_snap_nph   <= fc_nph;
          r_snap_npd   <= fc_npd;
          r_snap_cplh  <= fc_cplh;
          r_snap_cpld  <= fc_cpld;
          r_snap_valid <= 1'b1;
          r_state      <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (snap_ready) begin
            r_snap_valid <= 1'b0;
            if (r_snap_last) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_fc_sel <= r_fc_sel + 1'b1;
              r_wait   <= '0;
              r_state  <= ST_SETTLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign fc_sel     = r_fc_sel;
  assign busy       = r_busy;
  assign overrun    = r_overrun;
  assign snap_valid = r_snap_valid;
  assign snap_sel   = r_snap_sel;
  assign snap_last  = r_snap_last;
  assign snap_ph    = r_snap_ph;
  assign snap_pd    = r_snap_pd;
  assign snap_nph   = r_snap_nph;
  assign snap_npd   = r_snap_npd;
  assign snap_cplh  = r_snap_cplh;
  assign snap_cpld  = r_snap_cpld;

endmodule

// File: tb/tb_pcie_cfg_fc_sampler.sv
// Scoreboard bench for pcie_cfg_fc_sampler: three instances (basic, periodic, single SEL)
// fed by a core model that returns credits derived from fc_sel two cycles late.
module tb_pcie_cfg_fc_sampler;

  typedef struct {
    int inst;
    int sel;
    int last;
    int ph, pd, nph, npd, cplh, cpld;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n [3];
  logic        start [3];
  logic        ready [3];
  logic [2:0]  fc_sel [3];
  logic [2:0]  d1 [3];
  logic [2:0]  d2 [3];
  logic [7:0]  fc_ph [3];
  logic [11:0] fc_pd [3];
  logic [7:0]  fc_nph [3];
  logic [11:0] fc_npd [3];
  logic [7:0]  fc_cplh [3];
  logic [11:0] fc_cpld [3];
  logic        snap_valid [3];
  logic [2:0]  snap_sel [3];
  logic        snap_last [3];
  logic [7:0]  snap_ph [3];
  logic [11:0] snap_pd [3];
  logic [7:0]  snap_nph [3];
  logic [11:0] snap_npd [3];
  logic [7:0]  snap_cplh [3];
  logic [11:0] snap_cpld [3];
  logic        busy [3];
  logic        overrun [3];

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Core model: credits follow fc_sel with a two-cycle delay.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      d1[i] <= fc_sel[i];
      d2[i] <= d1[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      fc_ph[i]   = 8'h10 + {5'd0, d2[i]};
      fc_pd[i]   = 12'h100 + {9'd0, d2[i]};
      fc_nph[i]  = 8'h20 + {5'd0, d2[i]};
      fc_npd[i]  = 12'h300 + {9'd0, d2[i]};
      fc_cplh[i] = 8'h30 + {5'd0, d2[i]};
      fc_cpld[i] = 12'h200 + {9'd0, d2[i]};
    end
  end

  pcie_cfg_fc_sampler #(.C_NUM_SEL(3), .C_SEL_LATENCY(2), .C_PERIOD(0)) u_dut0 (
    .aclk(clk), .aresetn(rst_n[0]), .start(start[0]), .fc_sel(fc_sel[0]),
    .fc_ph(fc_ph[0]), .fc_pd(fc_pd[0]), .fc_nph(fc_nph[0]), .fc_npd(fc_npd[0]),
    .fc_cplh(fc_cplh[0]), .fc_cpld(fc_cpld[0]), .snap_valid(snap_valid[0]),
    .snap_ready(ready[0]), .snap_sel(snap_sel[0]), .snap_last(snap_last[0]),
    .snap_ph(snap_ph[0]), .snap_pd(snap_pd[0]), .snap_nph(snap_nph[0]), .snap_npd(snap_npd[0]),
    .snap_cplh(snap_cplh[0]), .snap_cpld(snap_cpld[0]), .busy(busy[0]), .overrun(overrun[0])
  );

  pcie_cfg_fc_sampler #(.C_NUM_SEL(3), .C_SEL_LATENCY(2), .C_PERIOD(40)) u_dut1 (
    .aclk(clk), .aresetn(rst_n[1]), .start(start[1]), .fc_sel(fc_sel[1]),
    .fc_ph(fc_ph[1]), .fc_pd(fc_pd[1]), .fc_nph(fc_nph[1]), .fc_npd(fc_npd[1]),
    .fc_cplh(fc_cplh[1]), .fc_cpld(fc_cpld[1]), .snap_valid(snap_valid[1]),
    .snap_ready(ready[1]), .snap_sel(snap_sel[1]), .snap_last(snap_last[1]),
    .snap_ph(snap_ph[1]), .snap_pd(snap_pd[1]), .snap_nph(snap_nph[1]), .snap_npd(snap_npd[1]),
    .snap_cplh(snap_cplh[1]), .snap_cpld(snap_cpld[1]), .busy(busy[1]), .overrun(overrun[1])
  );

  pcie_cfg_fc_sampler #(.C_NUM_SEL(1), .C_SEL_LATENCY(2), .C_PERIOD(0)) u_dut2 (
    .aclk(clk), .aresetn(rst_n[2]), .start(start[2]), .fc_sel(fc_sel[2]),
    .fc_ph(fc_ph[2]), .fc_pd(fc_pd[2]), .fc_nph(fc_nph[2]), .fc_npd(fc_npd[2]),
    .fc_cplh(fc_cplh[2]), .fc_cpld(fc_cpld[2]), .snap_valid(snap_valid[2]),
    .snap_ready(ready[2]), .snap_sel(snap_sel[2]), .snap_last(snap_last[2]),
    .snap_ph(snap_ph[2]), .snap_pd(snap_pd[2]), .snap_nph(snap_nph[2]), .snap_npd(snap_npd[2]),
    .snap_cplh(snap_cplh[2]), .snap_cpld(snap_cpld[2]), .busy(busy[2]), .overrun(overrun[2])
  );

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic void push_snap(input int inst, input int sel, input int last, input int at);
    exp_t e;
    e.inst = inst;  e.sel = sel;  e.last = last;
    e.ph   = 'h10 + sel;  e.pd  = 'h100 + sel;  e.nph  = 'h20 + sel;
    e.npd  = 'h300 + sel; e.cplh = 'h30 + sel;  e.cpld = 'h200 + sel;
    e.cyc  = at;
    sbq.push_back(e);
  endfunction

  // Trigger sampled at edge t; with ready high each SEL takes latency+2 = 4 cycles.
  function automatic void push_sweep(input int inst, input int t, input int n);
    for (int s = 0; s < n; s++) push_snap(inst, s, (s == n - 1) ? 1 : 0, t + 3 + 4 * s);
  endfunction

  task automatic check_snap(input int i);
    exp_t e;
    if (sbq.size() == 0) begin
      check_eq($sformatf("i%0d_extra_snap_cyc%0d", i, cyc), sbq.size(), 1);
    end else begin
      e = sbq.pop_front();
      $display("snap i%0d cyc=%0d sel=%0d last=%0d ph=%0h cpld=%0h", i, cyc, snap_sel[i],
               snap_last[i], snap_ph[i], snap_cpld[i]);
      check_eq($sformatf("i%0d_s%0d_inst", i, e.sel), i, e.inst);
      check_eq($sformatf("i%0d_s%0d_sel", i, e.sel), snap_sel[i], e.sel);
      check_eq($sformatf("i%0d_s%0d_last", i, e.sel), snap_last[i], e.last);
      check_eq($sformatf("i%0d_s%0d_ph", i, e.sel), snap_ph[i], e.ph);
      check_eq($sformatf("i%0d_s%0d_pd", i, e.sel), snap_pd[i], e.pd);
      check_eq($sformatf("i%0d_s%0d_nph", i, e.sel), snap_nph[i], e.nph);
      check_eq($sformatf("i%0d_s%0d_npd", i, e.sel), snap_npd[i], e.npd);
      check_eq($sformatf("i%0d_s%0d_cplh", i, e.sel), snap_cplh[i], e.cplh);
      check_eq($sformatf("i%0d_s%0d_cpld", i, e.sel), snap_cpld[i], e.cpld);
      check_eq($sformatf("i%0d_s%0d_cycle", i, e.sel), cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_n[i] && snap_valid[i] && ready[i]) check_snap(i);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) step();
  endtask

  task automatic pulse(input int i);
    start[i] = 1'b1;
    step();
    start[i] = 1'b0;
  endtask

  int t;
  int c;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      start[i] = 1'b0;
      ready[i] = 1'b1;
    end
    repeat (3) step();
    check_eq("rst_fc_sel", fc_sel[0], 0);
    check_eq("rst_valid", snap_valid[0], 0);
    check_eq("rst_busy", busy[0], 0);
    check_eq("rst_overrun", overrun[0], 0);
    check_eq("rst_snap_ph", snap_ph[0], 0);
    check_eq("rst_snap_cpld", snap_cpld[0], 0);
    rst_n[0] = 1'b1;
    repeat (10) step();

    // Basic sweep with ready held high
    t = cyc + 1;
    push_sweep(0, t, 3);
    pulse(0);
    wait_until(t + 11);
    check_eq("A_busy_before_end", busy[0], 1);
    step();
    check_eq("A_busy_end", busy[0], 0);
    check_eq("A_overrun", overrun[0], 0);
    check_eq("A_fc_sel_held", fc_sel[0], 2);
    check_eq("A_sb_empty", sbq.size(), 0);

    // Backpressure on the first snapshot for 20 cycles
    ready[0] = 1'b0;
    step();
    t = cyc + 1;
    push_snap(0, 0, 0, t + 22);
    push_snap(0, 1, 0, t + 26);
    push_snap(0, 2, 1, t + 30);
    pulse(0);
    wait_until(t + 3);
    for (int k = 0; k < 20; k++) begin
      check_eq($sformatf("B_valid_k%0d", k), snap_valid[0], 1);
      check_eq($sformatf("B_ph_k%0d", k), snap_ph[0], 'h10);
      check_eq($sformatf("B_fc_sel_k%0d", k), fc_sel[0], 0);
      if (k < 19) step();
    end
    ready[0] = 1'b1;
    wait_until(t + 32);
    check_eq("B_busy_end", busy[0], 0);
    check_eq("B_sb_empty", sbq.size(), 0);

    // Reset while settling SEL 1, then a fresh sweep
    t = cyc + 1;
    push_snap(0, 0, 0, t + 3);
    pulse(0);
    wait_until(t + 4);
    check_eq("D_fc_sel_pre", fc_sel[0], 1);
    rst_n[0] = 1'b0;
    #1;
    check_eq("D_fc_sel_rst", fc_sel[0], 0);
    check_eq("D_valid_rst", snap_valid[0], 0);
    check_eq("D_busy_rst", busy[0], 0);
    step();
    rst_n[0] = 1'b1;
    step();
    t = cyc + 1;
    push_sweep(0, t, 3);
    pulse(0);
    wait_until(t + 12);
    check_eq("D_busy_end", busy[0], 0);
    check_eq("D_overrun", overrun[0], 0);
    check_eq("D_sb_empty", sbq.size(), 0);

    // Start landing on the edge where busy falls is dropped
    t = cyc + 1;
    push_sweep(0, t, 3);
    pulse(0);
    wait_until(t + 11);
    pulse(0);
    check_eq("E_overrun", overrun[0], 1);
    check_eq("E_busy", busy[0], 0);
    repeat (8) step();
    check_eq("E_busy_later", busy[0], 0);
    check_eq("E_sb_empty", sbq.size(), 0);

    // Overrun clears only on reset; then a start in mid-sweep
    rst_n[0] = 1'b0;
    step();
    check_eq("C_overrun_rst", overrun[0], 0);
    rst_n[0] = 1'b1;
    step();
    t = cyc + 1;
    push_sweep(0, t, 3);
    pulse(0);
    repeat (3) step();
    pulse(0);
    check_eq("C_overrun_set", overrun[0], 1);
    wait_until(t + 12);
    check_eq("C_busy_end", busy[0], 0);
    repeat (20) step();
    check_eq("C_overrun_sticky", overrun[0], 1);
    check_eq("C_busy_idle", busy[0], 0);
    check_eq("C_sb_empty", sbq.size(), 0);

    // Periodic sweeps, period 40: triggers at cycles 39, 79, 119 after reset release
    c = cyc;
    push_sweep(1, c + 40, 3);
    push_sweep(1, c + 80, 3);
    push_sweep(1, c + 120, 3);
    rst_n[1] = 1'b1;
    wait_until(c + 39);
    check_eq("P_busy_pre", busy[1], 0);
    step();
    check_eq("P_busy_first", busy[1], 1);
    wait_until(c + 134);
    check_eq("P_overrun", overrun[1], 0);
    check_eq("P_busy_end", busy[1], 0);
    check_eq("P_sb_empty", sbq.size(), 0);
    rst_n[1] = 1'b0;

    // Single SEL per sweep
    rst_n[2] = 1'b1;
    step();
    t = cyc + 1;
    push_sweep(2, t, 1);
    pulse(2);
    wait_until(t + 3);
    check_eq("S_valid", snap_valid[2], 1);
    check_eq("S_last", snap_last[2], 1);
    step();
    check_eq("S_busy_end", busy[2], 0);
    check_eq("S_valid_end", snap_valid[2], 0);
    check_eq("S_fc_sel", fc_sel[2], 0);
    repeat (4) step();
    check_eq("final_sb_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pcie_cfg_fc_sampler.md
Name: pcie_cfg_fc_sampler

Overview:
Requester side of the PCIe configuration flow-control interface. Drives the SEL code into the PCIe core's FC port, waits a fixed core latency, then captures the returned PH/PD/NPH/NPD/CPLH/CPLD credit values. Each sweep covers C_NUM_SEL codes, and every capture is presented as a snapshot on a valid/ready stream. Sits between the core's FC port (or its wirethrough) and the shell's credit-monitoring logic.

Parameters:
C_PH_WIDTH, 8, posted header credit field width
C_PD_WIDTH, 12, posted data credit field width
C_NPH_WIDTH, 8, non-posted header credit field width
C_NPD_WIDTH, 12, non-posted data credit field width
C_CPLH_WIDTH, 8, completion header credit field width
C_CPLD_WIDTH, 12, completion data credit field width
C_SEL_WIDTH, 3, SEL code width
C_NUM_SEL, 3, number of SEL codes per sweep; codes 0..C_NUM_SEL-1; range 1..2^C_SEL_WIDTH
C_SEL_LATENCY, 2, cycles from a fc_sel change to valid credit data; range 1..15
C_PERIOD, 0, auto-sweep interval in cycles; 0 disables the periodic timer; max 2^24-1

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
start  in  1  single-cycle sweep request
fc_sel  out  C_SEL_WIDTH  SEL code driven to the core
fc_ph  in  C_PH_WIDTH  PH credits returned by the core
fc_pd  in  C_PD_WIDTH  PD credits returned by the core
fc_nph  in  C_NPH_WIDTH  NPH credits returned by the core
fc_npd  in  C_NPD_WIDTH  NPD credits returned by the core
fc_cplh  in  C_CPLH_WIDTH  CPLH credits returned by the core
fc_cpld  in  C_CPLD_WIDTH  CPLD credits returned by the core
snap_valid  out  1  snapshot available
snap_ready  in  1  consumer accepts the snapshot
snap_sel  out  C_SEL_WIDTH  SEL code of this snapshot
snap_last  out  1  last snapshot of the sweep
snap_ph, snap_pd, snap_nph, snap_npd, snap_cplh, snap_cpld  out  matching C_*_WIDTH  captured credit values
busy  out  1  sweep in progress
overrun  out  1  sticky flag: a trigger was dropped; cleared only by reset

Behaviour:
- Reset (async assert, sync deassert handled upstream): FSM IDLE. All outputs are 0, including fc_sel, snap_*, busy and overrun. Period counter is 0.
- Trigger = start OR (C_PERIOD>0 AND period counter reaches C_PERIOD-1).
- Period counter: increments every cycle, wraps to 0 when it fires, and runs whether or not the FSM is busy.
- FSM states: IDLE, SETTLE, CAPTURE, PRESENT.
- IDLE + trigger -> SETTLE. In the same transition: fc_sel<=0, wait counter<=0, busy<=1.
- SETTLE: wait counter increments each cycle. At C_SEL_LATENCY-1 -> CAPTURE. fc_sel is held stable throughout.
- CAPTURE, one cycle: register all six fc_* inputs into snap_* and fc_sel into snap_sel. Set snap_last=(fc_sel==C_NUM_SEL-1) and snap_valid<=1. Then -> PRESENT.
- PRESENT: hold all snap_* stable while snap_valid=1 and snap_ready=0. On snap_valid & snap_ready:
  - snap_valid<=0.
  - If snap_last: -> IDLE, busy<=0, fc_sel unchanged.
  - Else: fc_sel<=fc_sel+1, wait counter<=0, -> SETTLE.
- Latency: trigger at cycle T gives the first snap_valid at T+C_SEL_LATENCY+1.
- A sweep with ready held at 1 takes C_NUM_SEL*(C_SEL_LATENCY+2) cycles.
- Trigger while busy=1: the request is dropped, overrun<=1, and the current sweep is unaffected.
- Trigger in the same cycle busy falls (PRESENT->IDLE): counts as a busy-time trigger, so it is dropped and sets overrun.
- start and a timer expiry in the same cycle count as one trigger.
- C_NUM_SEL=1: every snapshot has snap_last=1.
- fc_sel increments never wrap within a sweep; the C_NUM_SEL range rule guarantees this.
- Reset mid-sweep: all state is cleared immediately, including a snapshot that is pending in PRESENT.
- Credit values are captured verbatim, with no arithmetic and no width conversion.

Decomposition:
- Shared package pcie_cfg_fc_pkg: FSM state enum, a snapshot struct holding sel, last and the six credit fields, and the default width constants.
- One sub-module, pcie_cfg_fc_trigger: period counter plus start merge, producing a single-cycle trigger pulse.
- The FSM and capture registers stay in the top module.

Test Plan:
- C_NUM_SEL=3, C_SEL_LATENCY=2, ready=1. Model returns ph=0x10+sel and cpld=0x200+sel with a 2-cycle delay from fc_sel. Pulse start at cycle 10 -> snapshots at cycles 13, 17, 21 with sel 0/1/2, ph 0x10/0x11/0x12, cpld 0x200/0x201/0x202, snap_last only on the third; busy low at cycle 22.
- Backpressure: hold ready=0 for 20 cycles after the first snap_valid -> snap_* stay stable, fc_sel stays 0, and the next snapshot arrives C_SEL_LATENCY+2 cycles after ready rises.
- Second start during a sweep -> overrun=1, still exactly 3 snapshots; overrun stays 1 until reset.
- C_PERIOD=40, ready=1, no start -> sweeps begin at cycles 39, 79, 119; overrun stays 0.
- aresetn low for 1 cycle while in SETTLE with fc_sel=1 -> fc_sel=0, snap_valid=0 and busy=0 immediately; a new start produces a fresh full sweep.
- C_NUM_SEL=1, start -> one snapshot with sel=0 and snap_last=1, then IDLE.
